uart_tx_serializer: RTL and testbench



---
 rtl/uart_pkg.sv | 50 +++++
 rtl/uart_bit_timer.sv | 27 ++
 rtl/uart_tx_serializer.sv | 134 +++++++++++++
 tb/tb_uart_tx_serializer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: LCR layout, TX FSM encoding, word-length codes.
// Parity helper masks the byte down to the transmitted word length.
package uart_pkg;

  localparam int DEF_OVERSAMPLE = 16;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  typedef struct packed {
    logic       dlab;
    logic       set_break;
    logic       stick_parity;
    logic       eps;
    logic       pen;
    logic       stb;
    logic [1:0] wls;
  } lcr_t;

  typedef struct packed {
    logic       stick;
    logic       eps;
    logic       pen;
    logic       stb;
    logic [1:0] wls;
  } tx_cfg_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  function automatic logic calc_parity(
    input logic [7:0] d,
    input logic [1:0] wls,
    input logic       eps,
    input logic       stick
  );
    logic [7:0] m;
    m = d & (8'hFF >> (2'd3 - wls));
    if (stick) return ~eps;
    return eps ? ^m : ~^m;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Counts baud ticks up to a programmable limit; strobes bit_done on the
// tick that completes the bit and wraps to zero on that same tick.
module uart_bit_timer #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          baud_pulse,
  input  logic [CW-1:0] limit,
  output logic          bit_done
);

  logic [CW-1:0] cnt;

  assign bit_done = baud_pulse && !clr &&
                    (cnt == limit - CW'(1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (baud_pulse) begin
      cnt <= bit_done ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// 16550-style TX serializer: FIFO pop, framing, parity, stop, break.
// Optional UART_TX_FRAME_CNT_EN adds frame_cnt_o (completed frames).
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        baud_pulse_i,
  input  logic        tx_fifo_empty_i,
  input  logic [7:0]  tx_fifo_dout_i,
  input  logic [1:0]  wls_i,
  input  logic        stb_i,
  input  logic        pen_i,
  input  logic        eps_i,
  input  logic        stick_parity_i,
  input  logic        set_break_i,
`ifdef UART_TX_FRAME_CNT_EN
  output logic [15:0] frame_cnt_o,
`endif
  output logic        tx_pop_o,
  output logic        sreg_empty_o,
  output logic        tx_o
);

  localparam int CW = $clog2(2 * OVERSAMPLE) + 1;

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_START  = START;
  localparam logic [2:0] ST_DATA   = DATA;
  localparam logic [2:0] ST_PARITY = PARITY;
  localparam logic [2:0] ST_STOP   = STOP;

  logic [2:0]    state;
  logic [2:0]    bit_idx;
  logic [7:0]    data;
  tx_cfg_t       cfg;
  logic          tx_q;
  logic          bit_done;
  logic          pop;
  logic          last_data;
  logic [CW-1:0] lim;

  // Stop length stretches to 1.5 bits only for 5-bit words.
  always_comb begin
    lim = CW'(OVERSAMPLE);
    if (state == ST_STOP && cfg.stb) begin
      lim = (cfg.wls == WLS_5) ? CW'(OVERSAMPLE + OVERSAMPLE / 2)
                               : CW'(2 * OVERSAMPLE);
    end
  end

  uart_bit_timer #(.CW(CW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clr        (state == ST_IDLE),
    .baud_pulse (baud_pulse_i),
    .limit      (lim),
    .bit_done   (bit_done)
  );

  assign pop = baud_pulse_i && !tx_fifo_empty_i &&
               (state == ST_IDLE ||
                (state == ST_STOP && bit_done));

  assign last_data = bit_idx == (3'd4 + {1'b0, cfg.wls});

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_idx <= '0;
      data    <= '0;
      cfg     <= '0;
      tx_q    <= 1'b1;
    end else if (pop) begin
      state   <= ST_START;
      bit_idx <= '0;
      data    <= tx_fifo_dout_i;
      cfg     <= '{stick: stick_parity_i, eps: eps_i,
                   pen: pen_i, stb: stb_i, wls: wls_i};
      tx_q    <= 1'b0;
    end else if (bit_done) begin
      unique case (state)
        ST_START: begin
          state   <= ST_DATA;
          bit_idx <= '0;
          tx_q    <= data[0];
        end
        ST_DATA: begin
          if (!last_data) begin
            bit_idx <= bit_idx + 3'd1;
            tx_q    <= data[bit_idx + 3'd1];
          end else if (cfg.pen) begin
            state <= ST_PARITY;
            tx_q  <= calc_parity(data, cfg.wls,
                                 cfg.eps, cfg.stick);
          end else begin
            state <= ST_STOP;
            tx_q  <= 1'b1;
          end
        end
        ST_PARITY: begin
          state <= ST_STOP;
          tx_q  <= 1'b1;
        end
        ST_STOP: begin
          state <= ST_IDLE;
          tx_q  <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

`ifdef UART_TX_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_o <= '0;
    end else if (state == ST_STOP && bit_done) begin
      frame_cnt_o <= frame_cnt_o + 16'd1;
    end
  end
`endif

  assign tx_pop_o     = pop;
  assign sreg_empty_o = (state == ST_IDLE);
  // Break gating sits after the flop so it acts immediately.
  assign tx_o         = tx_q & ~set_break_i;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer; each baud tick is two clocks.
// Build with +define+UART_TX_FRAME_CNT_EN to also check frame_cnt_o.
module tb_uart_tx_serializer;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_pulse_i;
  logic       tx_fifo_empty_i;
  logic [7:0] tx_fifo_dout_i;
  logic [1:0] wls_i;
  logic       stb_i;
  logic       pen_i;
  logic       eps_i;
  logic       stick_parity_i;
  logic       set_break_i;
  logic       tx_pop_o;
  logic       sreg_empty_o;
  logic       tx_o;
`ifdef UART_TX_FRAME_CNT_EN
  logic [15:0] frame_cnt_o;
`endif

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  int p0;
  logic [7:0] q[$];

  uart_tx_serializer #(.OVERSAMPLE(OS)) dut (
    .clk             (clk),
    .rst             (rst),
    .baud_pulse_i    (baud_pulse_i),
    .tx_fifo_empty_i (tx_fifo_empty_i),
    .tx_fifo_dout_i  (tx_fifo_dout_i),
    .wls_i           (wls_i),
    .stb_i           (stb_i),
    .pen_i           (pen_i),
    .eps_i           (eps_i),
    .stick_parity_i  (stick_parity_i),
    .set_break_i     (set_break_i),
`ifdef UART_TX_FRAME_CNT_EN
    .frame_cnt_o     (frame_cnt_o),
`endif
    .tx_pop_o        (tx_pop_o),
    .sreg_empty_o    (sreg_empty_o),
    .tx_o            (tx_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (tx_pop_o) pops <= pops + 1;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    tx_fifo_empty_i = 1'b0;
    tx_fifo_dout_i  = q[0];
  endtask

  task automatic fifo_pop();
    void'(q.pop_front());
    tx_fifo_empty_i = (q.size() == 0);
    tx_fifo_dout_i  = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  task automatic set_cfg(input logic [1:0] w, input logic s,
                         input logic p, input logic e,
                         input logic k);
    wls_i = w; stb_i = s; pen_i = p; eps_i = e; stick_parity_i = k;
  endtask

  task automatic bit_ticks(input string tag, input logic exp,
                           input int n);
    repeat (n) begin
      baud_pulse_i = 1'b1; #1;
      chk({tag, "_line"}, 16'(tx_o), 16'(exp));
      chk({tag, "_busy"}, 16'(sreg_empty_o), 16'd0);
      @(posedge clk); #1;
      baud_pulse_i = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic kick(input string tag);
    baud_pulse_i = 1'b1; #1;
    chk({tag, "_pop"}, 16'(tx_pop_o), 16'd1);
    chk({tag, "_idle"}, 16'(sreg_empty_o), 16'd1);
    chk({tag, "_idle_line"}, 16'(tx_o), 16'd1);
    @(posedge clk); #1;
    baud_pulse_i = 1'b0;
    fifo_pop();
    chk({tag, "_start_line"}, 16'(tx_o), 16'd0);
    chk({tag, "_start_busy"}, 16'(sreg_empty_o), 16'd0);
    @(posedge clk); #1;
  endtask

  task automatic stop_end(input string tag, input logic more);
    baud_pulse_i = 1'b1; #1;
    chk({tag, "_stop_line"}, 16'(tx_o), 16'd1);
    chk({tag, "_stop_pop"}, 16'(tx_pop_o), 16'(more));
    @(posedge clk); #1;
    baud_pulse_i = 1'b0;
    if (more) fifo_pop();
    chk({tag, "_after_empty"}, 16'(sreg_empty_o), 16'(!more));
    chk({tag, "_after_line"}, 16'(tx_o), 16'(!more));
    @(posedge clk); #1;
  endtask

  task automatic frame(input string tag, input logic [9:0] bits,
                       input int nbits, input int stop_ticks,
                       input logic more);
    bit_ticks({tag, "_start"}, 1'b0, OS);
    for (int i = 0; i < nbits; i++)
      bit_ticks({tag, "_bit"}, bits[i], OS);
    bit_ticks({tag, "_stop"}, 1'b1, stop_ticks - 1);
    stop_end(tag, more);
  endtask

  initial begin
    rst = 1'b1; baud_pulse_i = 1'b0;
    tx_fifo_empty_i = 1'b1; tx_fifo_dout_i = 8'h00;
    set_break_i = 1'b0;
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_line", 16'(tx_o), 16'd1);
    chk("rst_pop", 16'(tx_pop_o), 16'd0);
    chk("rst_empty", 16'(sreg_empty_o), 16'd1);
`ifdef UART_TX_FRAME_CNT_EN
    chk("rst_fcnt", frame_cnt_o, 16'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    baud_pulse_i = 1'b1; #1;
    chk("empty_nopop", 16'(tx_pop_o), 16'd0);
    @(posedge clk); #1;
    baud_pulse_i = 1'b0;
    chk("empty_idle", 16'(sreg_empty_o), 16'd1);
    @(posedge clk); #1;

    // 8N1 0xA5
    p0 = pops;
    push(8'hA5);
    kick("c1");
    frame("c1", 10'h0A5, 8, OS, 1'b0);
    chk("c1_pops", 16'(pops), 16'(p0 + 1));

    // 7E1 0x53, config changed mid-frame must not matter
    set_cfg(2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    push(8'h53);
    kick("c2");
    set_cfg(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    frame("c2", {2'b00, 1'b0, 7'h53}, 8, OS, 1'b0);

    // 5O1.5 0x1F
    set_cfg(2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    push(8'h1F);
    kick("c3");
    frame("c3", {4'b0000, 1'b0, 5'h1F}, 6, OS + OS / 2, 1'b0);

    // stick parity, eps=1 -> 0, eps=0 -> 1
    set_cfg(2'b11, 1'b0, 1'b1, 1'b1, 1'b1);
    push(8'h01);
    kick("stk1");
    frame("stk1", {1'b0, 1'b0, 8'h01}, 9, OS, 1'b0);
    set_cfg(2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
    push(8'h01);
    kick("stk0");
    frame("stk0", {1'b0, 1'b1, 8'h01}, 9, OS, 1'b0);

    // break during DATA: line low, timing intact
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    push(8'hFF);
    kick("brk");
    bit_ticks("brk_start", 1'b0, OS);
    bit_ticks("brk_b0", 1'b1, OS);
    set_break_i = 1'b1; #1;
    chk("brk_immediate", 16'(tx_o), 16'd0);
    bit_ticks("brk_held", 1'b0, 7 * OS);
    set_break_i = 1'b0; #1;
    chk("brk_release", 16'(tx_o), 16'd1);
    bit_ticks("brk_stop", 1'b1, OS - 1);
    stop_end("brk", 1'b0);

    // reset in data bit 3 of 0x55
    push(8'h55);
    kick("rst");
    bit_ticks("rst_start", 1'b0, OS);
    bit_ticks("rst_b0", 1'b1, OS);
    bit_ticks("rst_b1", 1'b0, OS);
    bit_ticks("rst_b2", 1'b1, OS);
    bit_ticks("rst_b3", 1'b0, 5);
    p0 = pops;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_line", 16'(tx_o), 16'd1);
    chk("mid_rst_empty", 16'(sreg_empty_o), 16'd1);
`ifdef UART_TX_FRAME_CNT_EN
    chk("mid_rst_fcnt", frame_cnt_o, 16'd0);
`endif
    repeat (4) begin
      baud_pulse_i = 1'b1; #1;
      chk("mid_rst_nopop", 16'(tx_pop_o), 16'd0);
      @(posedge clk); #1;
      baud_pulse_i = 1'b0;
      chk("mid_rst_idle", 16'(tx_o), 16'd1);
      @(posedge clk); #1;
    end
    chk("mid_rst_pops", 16'(pops), 16'(p0));

    // back-to-back 0x01, 0x02, 0x03
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    p0 = pops;
    push(8'h01); push(8'h02); push(8'h03);
    kick("b2b1");
    frame("b2b1", 10'h001, 8, OS, 1'b1);
    frame("b2b2", 10'h002, 8, OS, 1'b1);
    frame("b2b3", 10'h003, 8, OS, 1'b0);
    chk("b2b_pops", 16'(pops), 16'(p0 + 3));
`ifdef UART_TX_FRAME_CNT_EN
    chk("b2b_fcnt", frame_cnt_o, 16'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
